// File: rtl/mem_bus_arbiter.sv
// Fetch/data port arbiter onto a single req/ack memory bus.
// Round-robin between ports, with a bounded wait for acknowledge.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_q,
    output logic              i_done,
    input  logic              d_start,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_q,
    output logic              d_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic              i_pend;
    logic              d_pend;
    logic [ADDR_W-1:0] i_slot_addr;
    logic [ADDR_W-1:0] d_slot_addr;
    logic [DATA_W-1:0] d_slot_data;
    logic              d_slot_we;
    logic              sel_d;
    logic              last_d;
    logic [7:0]        cnt;

    logic pick_d;
    logic ack_ok;
    logic abort;
    logic fin;
    logic launch;

    always_comb begin
        pick_d   = d_pend && (!i_pend || !last_d);
        launch   = (state == IDLE) && (i_pend || d_pend);
        ack_ok   = (state == WAIT) && mem_ack;
        abort    = (state == WAIT) && !mem_ack && (cnt == 8'd1);
        fin      = ack_ok || abort;
        state_nx = state;
        unique case (state)
            IDLE:    if (launch) state_nx = GRANT;
            GRANT:   state_nx = WAIT;
            WAIT:    if (fin) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_pend      <= 1'b0;
            d_pend      <= 1'b0;
            i_slot_addr <= '0;
            d_slot_addr <= '0;
            d_slot_data <= '0;
            d_slot_we   <= 1'b0;
            sel_d       <= 1'b0;
            last_d      <= 1'b1;
            cnt         <= '0;
            i_q         <= '0;
            d_q         <= '0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            bus_err     <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
        end else begin
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            bus_err <= 1'b0;

            if (launch) begin
                sel_d   <= pick_d;
                mem_req <= 1'b1;
                if (pick_d) begin
                    mem_addr  <= d_slot_addr;
                    mem_wdata <= d_slot_data;
                    mem_we    <= d_slot_we;
                end else begin
                    mem_addr <= i_slot_addr;
                    mem_we   <= 1'b0;
                end
            end

            if (state == GRANT) cnt <= 8'(TIMEOUT);
            else if (state == WAIT && !fin) cnt <= cnt - 8'd1;

            // An abort returns zero so a stale value is never mistaken for data
            if (fin) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                last_d  <= sel_d;
                bus_err <= abort;
                if (sel_d) begin
                    d_done <= 1'b1;
                    d_pend <= 1'b0;
                    if (!mem_we) d_q <= ack_ok ? mem_rdata : '0;
                end else begin
                    i_done <= 1'b1;
                    i_pend <= 1'b0;
                    i_q    <= ack_ok ? mem_rdata : '0;
                end
            end

            if (i_start && !i_pend) begin
                i_pend      <= 1'b1;
                i_slot_addr <= i_addr;
            end
            if (d_start && !d_pend) begin
                d_pend      <= 1'b1;
                d_slot_addr <= d_addr;
                d_slot_data <= d_data;
                d_slot_we   <= d_we;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a delayed-ack memory model.
// Bus is built with a short timeout so aborts are reachable quickly.
module tb_mem_bus_arbiter;

    localparam int AW = 27;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_q;
    logic          i_done;
    logic          d_start;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_data;
    logic          d_we;
    logic [DW-1:0] d_q;
    logic          d_done;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          bus_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_addr   (i_addr),
        .i_q      (i_q),
        .i_done   (i_done),
        .d_start  (d_start),
        .d_addr   (d_addr),
        .d_data   (d_data),
        .d_we     (d_we),
        .d_q      (d_q),
        .d_done   (d_done),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .bus_err  (bus_err)
    );

    // Memory model: ack arrives ack_dly cycles after the first req cycle
    int   ack_dly = 1;
    int   reqcyc  = 0;
    logic model_ack = 1'b0;
    logic ack_man   = 1'b0;
    logic both_seen = 1'b0;

    assign mem_ack = model_ack | ack_man;

    always @(negedge clk) begin
        if (mem_req) reqcyc = reqcyc + 1;
        else         reqcyc = 0;
        model_ack = mem_req && (reqcyc == ack_dly + 1);
        if (i_done && d_done) both_seen = 1'b1;
    end

    int npass  = 0;
    int ncheck = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        ncheck++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            npass++;
    endtask

    logic          seen_we;
    int            reqcnt;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;

    task automatic run(output int cyc, output logic gi, output logic gd,
                       output logic ge);
        cyc = 0; gi = 0; gd = 0; ge = 0;
        seen_we = 0; reqcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            i_start = 0;
            d_start = 0;
            cyc++;
            if (mem_req) begin
                reqcnt++;
                seen_we    = seen_we | mem_we;
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
            end
            if (i_done || d_done) begin
                gi = i_done; gd = d_done; ge = bus_err;
                return;
            end
        end
        check("run_timeout", 0, 1);
    endtask

    int   cyc;
    logic gi, gd, ge;
    logic acc_req, acc_out;

    initial begin
        reset = 1; i_start = 0; d_start = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_data = '0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {mem_req, i_done, d_done, bus_err, mem_we}, 0);
        check("rst_q", {i_q, d_q}, 0);
        check("rst_bus", {mem_addr, mem_wdata}, 0);
        reset = 0;

        // Idle after reset
        acc_req = 0; acc_out = 0;
        repeat (20) begin
            @(negedge clk);
            acc_req |= mem_req;
            acc_out |= i_done | d_done | bus_err | mem_we | (|i_q) | (|d_q)
                     | (|mem_addr) | (|mem_wdata);
        end
        check("idle_req", acc_req, 0);
        check("idle_out", acc_out, 0);

        // Single fetch read, ack 2 cycles after req
        ack_dly = 2; mem_rdata = 32'hDEADBEEF;
        i_addr = 27'h0000010; i_start = 1;
        run(cyc, gi, gd, ge);
        check("rd_port", {gi, gd, ge}, 3'b100);
        check("rd_q", i_q, 32'hDEADBEEF);
        check("rd_we", seen_we, 0);
        check("rd_addr", last_addr, 27'h10);
        check("rd_lat", cyc, 5);
        @(negedge clk);
        check("rd_pulse", {i_done, mem_req}, 0);

        // Simultaneous starts; last grant was fetch so data goes first
        ack_dly = 1; mem_rdata = 32'hCAFEF00D;
        d_we = 1; d_addr = 27'h100; d_data = 32'h12345678; d_start = 1;
        i_addr = 27'h20; i_start = 1;
        run(cyc, gi, gd, ge);
        check("sim_first", {gi, gd, ge}, 3'b010);
        check("sim_wr_we", seen_we, 1);
        check("sim_wr_bus", {last_addr, last_wdata}, {27'h100, 32'h12345678});
        check("sim_wr_dq", d_q, 0);
        check("sim_min_lat", cyc, 4);
        i_addr = 27'h777; i_start = 1;
        run(cyc, gi, gd, ge);
        check("sim_second", {gi, gd, ge}, 3'b100);
        check("sim_rd_q", i_q, 32'hCAFEF00D);
        check("ign_start", last_addr, 27'h20);
        check("sim_rd_we", seen_we, 0);
        acc_req = 0;
        repeat (6) begin
            @(negedge clk);
            acc_req |= mem_req;
        end
        check("ign_noreq", acc_req, 0);
        check("wr_dq_keep", d_q, 0);

        // Fairness with immediate re-requests
        d_we = 0; d_addr = 27'h200; d_start = 1;
        i_addr = 27'h300; i_start = 1;
        for (int k = 0; k < 6; k++) begin
            ack_dly = 1 + (k % 3);
            mem_rdata = 32'hA0 + k;
            run(cyc, gi, gd, ge);
            check($sformatf("rr_%0d", k), {gi, gd}, (k % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_q_%0d", k), gd ? d_q : i_q, 32'hA0 + k);
            if (k < 4) begin
                if (gd) d_start = 1;
                else    i_start = 1;
            end
        end

        // Timeout on a data read
        ack_dly = 255; d_we = 0; d_addr = 27'h44; d_start = 1;
        run(cyc, gi, gd, ge);
        check("to_port", {gi, gd, ge}, 3'b011);
        check("to_reqcyc", reqcnt, 5);
        check("to_dq", d_q, 0);
        check("to_lat", cyc, 7);
        @(negedge clk);
        check("to_pulse", {d_done, bus_err, mem_req}, 0);

        // Ack in the last WAIT cycle beats the abort
        ack_dly = 4; mem_rdata = 32'h5555AAAA;
        i_addr = 27'h55; i_start = 1;
        run(cyc, gi, gd, ge);
        check("late_port", {gi, gd, ge}, 3'b100);
        check("late_q", i_q, 32'h5555AAAA);
        check("late_lat", cyc, 7);

        // Reset while waiting drops the transfer
        ack_dly = 255; i_addr = 27'h66; i_start = 1;
        @(negedge clk); i_start = 0;
        @(negedge clk);
        @(negedge clk);
        check("wait_req", mem_req, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("rstw_req", {mem_req, i_done, d_done, bus_err}, 0);
        ack_man = 1;
        @(negedge clk);
        ack_man = 0;
        acc_req = 0; acc_out = 0;
        repeat (8) begin
            @(negedge clk);
            acc_req |= mem_req;
            acc_out |= i_done | d_done | bus_err;
        end
        check("rstw_noreq", acc_req, 0);
        check("rstw_nodone", acc_out, 0);
        check("rstw_q", {i_q, d_q}, 0);

        // After reset last grant is data, so fetch wins a tie
        ack_dly = 1; mem_rdata = 32'h0BADF00D;
        d_addr = 27'h11; d_start = 1;
        i_addr = 27'h22; i_start = 1;
        run(cyc, gi, gd, ge);
        check("rr_rst_first", {gi, gd}, 2'b10);
        run(cyc, gi, gd, ge);
        check("rr_rst_second", {gi, gd}, 2'b01);
        check("excl_done", both_seen, 0);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
